// File: rtl/usb_ft1248_device.sv
// FT1248 device-side responder: oversamples the host's SCLK/SS_n/MIOSI in the
// clk domain and bridges host writes into an RX FIFO and host reads out of a
// TX FIFO.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; usb_miso advertises TX FIFO empty (1) / data (0)
// CMD   | waiting for the command byte on the first rise, answer on fall
// TURN  | one full usb_clk period of bus turnaround
// WRITE | host->device data; each rise pushes into the RX FIFO
// READ  | device->host data; each rise pops the TX FIFO
// NAK   | transaction refused; usb_miso held high until usb_cs rises
module usb_ft1248_device #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [7:0]  CMD_WRITE  = 8'h00,
   parameter logic [7:0]  CMD_READ   = 8'h04
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       usb_clk,
   input  logic       usb_cs,
   output logic       usb_miso,
   input  logic [7:0] usb_miosi_in,
   output logic [7:0] usb_miosi_out,
   output logic       usb_miosi_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       nack
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_TURN,
      S_WRITE,
      S_READ,
      S_NAK
   } state_t;

   // [0],[1] synchronizer stages, [2] previous value for edge detection
   logic [2:0] sclk_q;
   logic [2:0] cs_q;

   logic cs_sync;
   logic rise;
   logic fall;
   logic cs_fall;

   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [PW-1:0] rx_wr_q;
   logic [PW-1:0] rx_rd_q;
   logic          rx_empty;
   logic          rx_full;
   logic          rx_push;
   logic          rx_pop;

   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [PW-1:0] tx_wr_q;
   logic [PW-1:0] tx_rd_q;
   logic          tx_empty;
   logic          tx_full;
   logic          tx_push;
   logic          tx_pop;
   logic [7:0]    tx_head;

   state_t     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic       seen_q, seen_d;
   logic       wr_ok_q, wr_ok_d;
   logic       miso_q, miso_d;
   logic       oe_q, oe_d;
   logic [7:0] out_q, out_d;
   logic       nack_q, nack_d;
   logic       cmd_ok;

   // Pin synchronizers; reset to the bus idle levels (SCLK low, SS_n high)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sclk_q <= 3'b000;
         cs_q   <= 3'b111;
      end else begin
         sclk_q <= {sclk_q[1:0], usb_clk};
         cs_q   <= {cs_q[1:0], usb_cs};
      end
   end

   assign cs_sync = cs_q[1];
   assign rise    =  sclk_q[1] & ~sclk_q[2] & ~cs_sync;
   assign fall    = ~sclk_q[1] &  sclk_q[2] & ~cs_sync;
   assign cs_fall = ~cs_q[1] & cs_q[2];

   assign rx_empty = (rx_wr_q == rx_rd_q);
   assign rx_full  = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);
   assign rx_pop   = ~rx_empty & rx_ready;
   assign tx_empty = (tx_wr_q == tx_rd_q);
   assign tx_full  = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
   assign tx_push  = tx_valid & ~tx_full;
   assign tx_head  = tx_mem[tx_rd_q[AW-1:0]];

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_q[AW-1:0]] <= usb_miosi_in;
      if (tx_push) tx_mem[tx_wr_q[AW-1:0]] <= tx_data;
   end

   // FIFO pointers; host-side and pin-side accesses are independent
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_q <= '0;
         rx_rd_q <= '0;
         tx_wr_q <= '0;
         tx_rd_q <= '0;
      end else begin
         rx_wr_q <= rx_wr_q + PW'(rx_push);
         rx_rd_q <= rx_rd_q + PW'(rx_pop);
         tx_wr_q <= tx_wr_q + PW'(tx_push);
         tx_rd_q <= tx_rd_q + PW'(tx_pop);
      end
   end

   assign cmd_ok = ((cmd_q == CMD_WRITE) && !rx_full) || ((cmd_q == CMD_READ) && !tx_empty);

   // Protocol FSM: next state, pin outputs and FIFO strobes
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      seen_d  = seen_q;
      wr_ok_d = wr_ok_q;
      miso_d  = miso_q;
      oe_d    = oe_q;
      out_d   = out_q;
      nack_d  = 1'b0;
      rx_push = 1'b0;
      tx_pop  = 1'b0;
      if (state_q != S_IDLE && cs_sync) begin
         // A byte whose rise was never seen has had no FIFO effect
         state_d = S_IDLE;
         oe_d    = 1'b0;
         seen_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               oe_d   = 1'b0;
               seen_d = 1'b0;
               miso_d = tx_empty;
               if (cs_fall) state_d = S_CMD;
            end
            S_CMD: begin
               if (rise) begin
                  cmd_d  = usb_miosi_in;
                  seen_d = 1'b1;
               end else if (fall && seen_q) begin
                  seen_d = 1'b0;
                  if (cmd_ok) begin
                     miso_d  = 1'b0;
                     state_d = S_TURN;
                  end else begin
                     miso_d  = 1'b1;
                     nack_d  = 1'b1;
                     state_d = S_NAK;
                  end
               end
            end
            S_TURN: begin
               if (rise) begin
                  seen_d = 1'b1;
               end else if (fall && seen_q) begin
                  seen_d = 1'b0;
                  if (cmd_q == CMD_READ) begin
                     oe_d    = 1'b1;
                     out_d   = tx_head;
                     miso_d  = 1'b0;
                     state_d = S_READ;
                  end else begin
                     state_d = S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               if (rise) begin
                  seen_d  = 1'b1;
                  wr_ok_d = ~rx_full;
                  rx_push = ~rx_full;
               end else if (fall && seen_q) begin
                  seen_d = 1'b0;
                  if (wr_ok_q) begin
                     miso_d = 1'b0;
                  end else begin
                     miso_d  = 1'b1;
                     nack_d  = 1'b1;
                     state_d = S_NAK;
                  end
               end
            end
            S_READ: begin
               if (rise) begin
                  seen_d = 1'b1;
                  tx_pop = ~tx_empty;
               end else if (fall && seen_q) begin
                  seen_d = 1'b0;
                  if (!tx_empty) begin
                     out_d  = tx_head;
                     miso_d = 1'b0;
                  end else begin
                     miso_d  = 1'b1;
                     nack_d  = 1'b1;
                     state_d = S_NAK;
                  end
               end
            end
            S_NAK: begin
               miso_d = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   // FSM and registered pin outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cmd_q   <= 8'h00;
         seen_q  <= 1'b0;
         wr_ok_q <= 1'b0;
         miso_q  <= 1'b1;
         oe_q    <= 1'b0;
         out_q   <= 8'h00;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         seen_q  <= seen_d;
         wr_ok_q <= wr_ok_d;
         miso_q  <= miso_d;
         oe_q    <= oe_d;
         out_q   <= out_d;
         nack_q  <= nack_d;
      end
   end

   assign usb_miso      = miso_q;
   assign usb_miosi_oe  = oe_q;
   assign usb_miosi_out = out_q;
   assign nack          = nack_q;
   assign busy          = (state_q != S_IDLE);
   assign rx_data       = rx_mem[rx_rd_q[AW-1:0]];
   assign rx_valid      = ~rx_empty;
   assign tx_ready      = ~tx_full;

endmodule

// File: tb/tb_usb_ft1248_device.sv
// Bench for usb_ft1248_device: an FT1248 host model drives the pins while
// queue-based models of both FIFOs predict every ACK/NAK and data byte.
module tb_usb_ft1248_device;

   localparam int D = 8;

   logic       clk;
   logic       reset;
   logic       usb_clk;
   logic       usb_cs;
   logic       usb_miso;
   logic [7:0] usb_miosi_in;
   logic [7:0] usb_miosi_out;
   logic       usb_miosi_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       nack;

   int checks   = 0;
   int failures = 0;
   int nack_cnt = 0;
   int nack_exp = 0;

   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   logic [7:0] stim[$];

   usb_ft1248_device #(.FIFO_DEPTH(D), .CMD_WRITE(8'h00), .CMD_READ(8'h04)) dut (
      .clk(clk), .reset(reset), .usb_clk(usb_clk), .usb_cs(usb_cs),
      .usb_miso(usb_miso), .usb_miosi_in(usb_miosi_in), .usb_miosi_out(usb_miosi_out),
      .usb_miosi_oe(usb_miosi_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .busy(busy), .nack(nack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count cycles with nack high; single-cycle pulses make this the NAK count
   always @(negedge clk) if (nack === 1'b1) nack_cnt++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One host SCLK period; s = MIOSI seen before the rise, m = MISO after the fall
   task automatic host_byte(input logic [7:0] d, output logic m, output logic [7:0] s);
      s = usb_miosi_out;
      usb_miosi_in = d;
      usb_clk = 1'b1;
      wait_clk(8);
      usb_clk = 1'b0;
      wait_clk(8);
      m = usb_miso;
   endtask

   task automatic begin_txn();
      usb_cs = 1'b0;
      wait_clk(8);
   endtask

   task automatic end_txn();
      int lat;
      lat = 0;
      @(posedge clk);
      #1 usb_cs = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         #1;
         if (!usb_miosi_oe && !busy) begin
            lat = i;
            break;
         end
      end
      checks++;
      if (lat != 3) begin
         failures++;
         $display("FAIL cs_release_latency: got %0d clk expected 3", lat);
      end
      wait_clk(4);
      checks++;
      if (nack_cnt != nack_exp) begin
         failures++;
         $display("FAIL nack_count: got %0d expected %0d", nack_cnt, nack_exp);
      end
      checks++;
      if (usb_miso !== (txq.size() == 0)) begin
         failures++;
         $display("FAIL idle_miso: got %b expected %b", usb_miso, (txq.size() == 0));
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      bit room;
      room = (txq.size() < D);
      @(negedge clk);
      checks++;
      if (tx_ready !== room) begin
         failures++;
         $display("FAIL tx_ready: got %b expected %b", tx_ready, room);
      end
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      if (room) txq.push_back(d);
   endtask

   task automatic drain_rx();
      int n;
      int exp_n;
      logic [7:0] e;
      n = 0;
      exp_n = rxq.size();
      for (int i = 0; i < D + 2; i++) begin
         @(negedge clk);
         if (rx_valid !== 1'b1) break;
         n++;
         e = (rxq.size() > 0) ? rxq.pop_front() : 8'hxx;
         checks++;
         if (rx_data !== e) begin
            failures++;
            $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
         end
         rx_ready = 1'b1;
         @(negedge clk);
         rx_ready = 1'b0;
      end
      checks++;
      if (n != exp_n) begin
         failures++;
         $display("FAIL rx_count: got %0d expected %0d", n, exp_n);
      end
      rxq.delete();
   endtask

   // Host write of the bytes in stim; model decides each ACK from RX occupancy
   task automatic do_write();
      logic m;
      logic [7:0] s;
      bit dead;
      bit exp;
      begin_txn();
      host_byte(8'h00, m, s);
      dead = (rxq.size() >= D);
      checks++;
      if (m !== dead) begin
         failures++;
         $display("FAIL write_cmd_miso: got %b expected %b", m, dead);
      end
      if (dead) nack_exp++;
      else host_byte(8'h00, m, s);
      foreach (stim[i]) begin
         host_byte(stim[i], m, s);
         if (dead) exp = 1'b1;
         else if (rxq.size() < D) begin
            rxq.push_back(stim[i]);
            exp = 1'b0;
         end else begin
            exp = 1'b1;
            dead = 1'b1;
            nack_exp++;
         end
         checks++;
         if (m !== exp) begin
            failures++;
            $display("FAIL write_byte_miso: byte %0d got %b expected %b", i, m, exp);
         end
      end
      end_txn();
   endtask

   // Host read of n bytes; model supplies the expected byte stream and NAK point
   task automatic do_read(input int n);
      logic m;
      logic [7:0] s;
      logic [7:0] e;
      bit dead;
      bit exp;
      begin_txn();
      host_byte(8'h04, m, s);
      dead = (txq.size() == 0);
      checks++;
      if (m !== dead) begin
         failures++;
         $display("FAIL read_cmd_miso: got %b expected %b", m, dead);
      end
      if (dead) nack_exp++;
      else begin
         host_byte(8'hFF, m, s);
         checks++;
         if (usb_miosi_oe !== 1'b1 || m !== 1'b0) begin
            failures++;
            $display("FAIL turn_read: got oe=%b miso=%b expected oe=1 miso=0", usb_miosi_oe, m);
         end
      end
      for (int i = 0; i < n; i++) begin
         host_byte(8'($urandom), m, s);
         if (!dead) begin
            e = txq.pop_front();
            checks++;
            if (s !== e) begin
               failures++;
               $display("FAIL read_data: byte %0d got %02h expected %02h", i, s, e);
            end
            exp = (txq.size() == 0);
            if (exp) begin
               dead = 1'b1;
               nack_exp++;
            end
         end else exp = 1'b1;
         checks++;
         if (m !== exp) begin
            failures++;
            $display("FAIL read_byte_miso: byte %0d got %b expected %b", i, m, exp);
         end
      end
      end_txn();
   endtask

   task automatic test_reset();
      checks++;
      if (usb_miso !== 1'b1 || usb_miosi_oe !== 1'b0 || usb_miosi_out !== 8'h00 ||
          rx_valid !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0 || nack !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got miso=%b oe=%b out=%02h rxv=%b txr=%b busy=%b nack=%b expected 1 0 00 0 1 0 0",
                  usb_miso, usb_miosi_oe, usb_miosi_out, rx_valid, tx_ready, busy, nack);
      end
   endtask

   task automatic test_write_basic();
      stim.delete();
      stim.push_back(8'hA5);
      stim.push_back(8'h5A);
      stim.push_back(8'h3C);
      do_write();
      drain_rx();
   endtask

   task automatic test_read_basic();
      push_tx(8'h11);
      push_tx(8'h22);
      do_read(3);
   endtask

   task automatic test_overflow();
      stim.delete();
      for (int i = 0; i < D + 1; i++) stim.push_back(8'($urandom));
      do_write();
      drain_rx();
   endtask

   task automatic test_unknown_cmd();
      logic m;
      logic [7:0] s;
      push_tx(8'h6D);
      begin_txn();
      host_byte(8'h20, m, s);
      nack_exp++;
      checks++;
      if (m !== 1'b1) begin
         failures++;
         $display("FAIL unknown_cmd_miso: got %b expected 1", m);
      end
      host_byte(8'h99, m, s);
      host_byte(8'h98, m, s);
      checks++;
      if (m !== 1'b1 || usb_miosi_oe !== 1'b0) begin
         failures++;
         $display("FAIL unknown_cmd_hold: got miso=%b oe=%b expected 1 0", m, usb_miosi_oe);
      end
      end_txn();
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL unknown_cmd_rx: got rx_valid=%b expected 0", rx_valid);
      end
      do_read(1);
   endtask

   task automatic test_idle_miso();
      do_read(1);
      @(negedge clk);
      tx_data  = 8'h7E;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      txq.push_back(8'h7E);
      checks++;
      if (usb_miso !== 1'b1) begin
         failures++;
         $display("FAIL idle_miso_push_edge: got %b expected 1", usb_miso);
      end
      @(negedge clk);
      checks++;
      if (usb_miso !== 1'b0) begin
         failures++;
         $display("FAIL idle_miso_after_push: got %b expected 0", usb_miso);
      end
      do_read(1);
   endtask

   task automatic test_partial();
      logic m;
      logic [7:0] s;
      push_tx(8'h33);
      begin_txn();
      host_byte(8'h04, m, s);
      host_byte(8'hFF, m, s);
      usb_miosi_in = 8'hC1;
      end_txn();
      do_read(1);
      push_tx(8'h55);
      begin_txn();
      host_byte(8'h00, m, s);
      host_byte(8'h00, m, s);
      host_byte(8'h44, m, s);
      rxq.push_back(8'h44);
      usb_miosi_in = 8'h99;
      usb_clk = 1'b1;
      wait_clk(1);
      checks++;
      if (rx_valid !== 1'b1 || usb_miso !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: got rxv=%b miso=%b busy=%b expected 1 0 1", rx_valid, usb_miso, busy);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (usb_miso !== 1'b1 || usb_miosi_oe !== 1'b0 || usb_miosi_out !== 8'h00 ||
          rx_valid !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0 || nack !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got miso=%b oe=%b out=%02h rxv=%b txr=%b busy=%b nack=%b expected 1 0 00 0 1 0 0",
                  usb_miso, usb_miosi_oe, usb_miosi_out, rx_valid, tx_ready, busy, nack);
      end
      rxq.delete();
      txq.delete();
      usb_clk = 1'b0;
      usb_cs  = 1'b1;
      wait_clk(3);
      reset = 1'b1;
      wait_clk(8);
      checks++;
      if (rx_valid !== 1'b0 || usb_miso !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset: got rxv=%b miso=%b busy=%b expected 0 1 0", rx_valid, usb_miso, busy);
      end
   endtask

   task automatic test_random();
      int k;
      for (int it = 0; it < 10; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            stim.delete();
            k = $urandom_range(1, 10);
            for (int i = 0; i < k; i++) stim.push_back(8'($urandom));
            do_write();
         end else begin
            k = $urandom_range(0, 3);
            for (int i = 0; i < k; i++) push_tx(8'($urandom));
            do_read($urandom_range(1, 5));
         end
         if ($urandom_range(0, 2) == 0) drain_rx();
      end
      drain_rx();
   endtask

   task automatic test_back_to_back();
      while (txq.size() < D) push_tx(8'($urandom));
      push_tx(8'hEE);
      do_read(D);
      stim.delete();
      for (int i = 0; i < 4; i++) stim.push_back(8'($urandom));
      do_write();
      stim.delete();
      for (int i = 0; i < 6; i++) stim.push_back(8'($urandom));
      do_write();
      drain_rx();
   endtask

   initial begin
      reset        = 1'b0;
      usb_clk      = 1'b0;
      usb_cs       = 1'b1;
      usb_miosi_in = 8'h00;
      rx_ready     = 1'b0;
      tx_data      = 8'h00;
      tx_valid     = 1'b0;
      wait_clk(5);
      reset = 1'b1;
      wait_clk(2);
      test_reset();
      test_write_basic();
      test_read_basic();
      test_overflow();
      test_unknown_cmd();
      test_idle_miso();
      test_partial();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
